// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the word-memory responder.
package mem_responder_pkg;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } memresp_state_t;

  localparam logic [7:0] MEMRESP_LFSR_SEED   = 8'hA5;
  localparam int         MEMRESP_MAX_LATENCY = 15;
  // Worst case load value is MAX_LATENCY-1 plus up to 3 stall cycles.
  localparam int         MEMRESP_CNT_W       = $clog2(MEMRESP_MAX_LATENCY + 4);

endpackage

// File: rtl/mem_responder_if.sv
// Word memory port between the core (master) and the responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic      mem_read;
  logic      mem_write;
  rv32i_word mem_address;
  rv32i_word mem_wdata;
  logic [3:0] mem_byte_enable;
  rv32i_word mem_rdata;
  logic      mem_resp;
  logic      busy;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  mem_rdata, mem_resp, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output mem_rdata, mem_resp, busy
  );

endinterface

// File: rtl/mem_responder_byte_ram.sv
// Word array with four byte lanes: per-lane synchronous write and a
// registered read, written so FPGA tools can map it onto block RAM.
module mem_responder_byte_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  rv32i_word         wdata,
  output rv32i_word         q
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [3:0][7:0] mem [DEPTH];

  // Lane-enabled write; contents are intentionally never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[idx][i] <= wdata[8*i +: 8];
    end
  end

  // Registered read; q holds the last word read until the next read.
  always_ff @(posedge clk) begin
    if (re) q <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a held read/write request and answers
// with a one-cycle mem_resp after LATENCY cycles.
// Optional macro MEM_RESPONDER_STALL_EN adds 0..3 pseudo-random stall
// cycles per transaction from an 8-bit LFSR.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  mem_responder_if.slave bus
);

  localparam int CNT_W = MEMRESP_CNT_W;

  memresp_state_t     state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  idx_q;
  rv32i_word          wdata_q;
  logic [3:0]         be_q;
  logic               wr_q;
  logic               resp_q;
  logic               busy_q;
  logic               rdata_vld;
  rv32i_word          ram_q;

  logic [1:0]         extra;
  logic [CNT_W-1:0]   load_cnt;
  logic               req;
  logic               enter_resp;
  logic [ADDR_W-1:0]  cur_idx;
  rv32i_word          cur_wdata;
  logic [3:0]         cur_be;
  logic               cur_wr;
  logic               ram_we;
  logic               ram_re;
  logic               addr_unused;

  assign addr_unused = ^{bus.mem_address[31:ADDR_W+2], bus.mem_address[1:0]};

`ifdef MEM_RESPONDER_STALL_EN
  logic [7:0] lfsr;

  // Free-running Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= MEMRESP_LFSR_SEED;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign extra = lfsr[1:0];
`else
  assign extra = 2'd0;
`endif

  // In IDLE the RAM sees the live request so LATENCY=1 can complete on
  // the accepting edge; afterwards it sees the captured transaction.
  always_comb begin
    req        = bus.mem_read | bus.mem_write;
    load_cnt   = CNT_W'(LATENCY - 1) + CNT_W'(extra);
    enter_resp = 1'b0;
    cur_idx    = idx_q;
    cur_wdata  = wdata_q;
    cur_be     = be_q;
    cur_wr     = wr_q;
    if (state == IDLE) begin
      cur_idx    = bus.mem_address[ADDR_W+1:2];
      cur_wdata  = bus.mem_wdata;
      cur_be     = bus.mem_byte_enable;
      cur_wr     = bus.mem_write;
      enter_resp = req && (load_cnt == '0);
    end else if (state == WAIT) begin
      enter_resp = (cnt == CNT_W'(1));
    end
    ram_we = enter_resp && cur_wr;
    ram_re = enter_resp && !cur_wr;
  end

  // Transaction FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      wr_q      <= 1'b0;
      resp_q    <= 1'b0;
      busy_q    <= 1'b0;
      rdata_vld <= 1'b0;
    end else begin
      resp_q <= enter_resp;
      if (ram_re) rdata_vld <= 1'b1;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= bus.mem_address[ADDR_W+1:2];
            wdata_q <= bus.mem_wdata;
            be_q    <= bus.mem_byte_enable;
            wr_q    <= bus.mem_write;
            cnt     <= load_cnt;
            busy_q  <= 1'b1;
            state   <= (load_cnt == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  mem_responder_byte_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .be    (cur_be),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .q     (ram_q)
  );

  // Read data is zero until the first read completes after reset.
  assign bus.mem_rdata = rdata_vld ? ram_q : '0;
  assign bus.mem_resp  = resp_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at LATENCY=2 for the
// functional vectors and one at LATENCY=4 for reset-abort behaviour.
module tb_mem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
  localparam int LAT_C = 1;

  logic        clk;
  logic        rst_a, rst_b, rst_c;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  int          sel;
  logic        obs_resp, obs_busy;
  logic [31:0] obs_rdata;
  int          n_checks, n_errors;

  mem_responder_if ifa ();
  mem_responder_if ifb ();
  mem_responder_if ifc ();

  assign ifa.mem_read = req_read;
  assign ifa.mem_write = req_write;
  assign ifa.mem_address = req_addr;
  assign ifa.mem_wdata = req_wdata;
  assign ifa.mem_byte_enable = req_be;
  assign ifb.mem_read = req_read;
  assign ifb.mem_write = req_write;
  assign ifb.mem_address = req_addr;
  assign ifb.mem_wdata = req_wdata;
  assign ifb.mem_byte_enable = req_be;
  assign ifc.mem_read = req_read;
  assign ifc.mem_write = req_write;
  assign ifc.mem_address = req_addr;
  assign ifc.mem_wdata = req_wdata;
  assign ifc.mem_byte_enable = req_be;

  mem_responder #(.ADDR_W(10), .LATENCY(LAT_A)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  mem_responder #(.ADDR_W(10), .LATENCY(LAT_B)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
  mem_responder #(.ADDR_W(10), .LATENCY(LAT_C)) dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

  always_comb begin
    obs_resp  = ifa.mem_resp;
    obs_busy  = ifa.busy;
    obs_rdata = ifa.mem_rdata;
    if (sel == 1) begin
      obs_resp  = ifb.mem_resp;
      obs_busy  = ifb.busy;
      obs_rdata = ifb.mem_rdata;
    end else if (sel == 2) begin
      obs_resp  = ifc.mem_resp;
      obs_busy  = ifc.busy;
      obs_rdata = ifc.mem_rdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int lat, input int exp);
`ifdef MEM_RESPONDER_STALL_EN
    check_val(tag, 32'((lat >= exp) && (lat <= exp + 3)), 32'd1);
`else
    check_val(tag, 32'(lat), 32'(exp));
`endif
  endtask

  // Entered and left at #1 after a rising edge. hold>0 drops the request
  // after that many edges; otherwise it is held until mem_resp.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     output int lat, output logic [31:0] rdata);
    req_read = rd; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    lat = -1;
    rdata = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (hold > 0 && k == hold) begin req_read = 1'b0; req_write = 1'b0; end
      if (obs_resp) begin lat = k; rdata = obs_rdata; break; end
    end
    req_read = 1'b0; req_write = 1'b0;
    @(posedge clk); #1;
    check_val("no_adjacent_resp", 32'(obs_resp), 32'd0);
  endtask

  int          lat, k1, k2, pulses;
  logic [31:0] rd;
  int          hist [1:4];

  initial begin
    n_checks = 0; n_errors = 0; sel = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    for (int i = 1; i <= 4; i++) hist[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_resp", 32'(obs_resp), 32'd0);
    check_val("rst_busy", 32'(obs_busy), 32'd0);
    check_val("rst_rdata", obs_rdata, 32'd0);
    rst_a = 1'b1;
    @(posedge clk); #1;

    // write then read
    txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 0, lat, rd);
    check_lat("wr_lat", lat, LAT_A);
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 0, lat, rd);
    check_lat("rd_lat", lat, LAT_A);
    check_val("rd_data", rd, 32'hDEADBEEF);

    // byte lanes
    txn(1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 4'b1111, 0, lat, rd);
    txn(1'b0, 1'b1, 32'h0000_0020, 32'h00AB0000, 4'b0100, 0, lat, rd);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b1111, 0, lat, rd);
    check_val("sb_merge", rd, 32'h11AB3344);
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'b0000, 0, lat, rd);
    check_lat("be0_lat", lat, LAT_A);
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, lat, rd);
    check_val("be0_unchanged", rd, 32'h11AB3344);

    // address wrap
    txn(1'b0, 1'b1, 32'h0000_1004, 32'h5A5A5A5A, 4'b1111, 0, lat, rd);
    txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 4'b0000, 0, lat, rd);
    check_val("wrap_data", rd, 32'h5A5A5A5A);

    // back-to-back with request held
    req_read = 1'b1; req_addr = 32'h0000_0010; k1 = -1; k2 = -1; rd = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (obs_resp) begin
        if (k1 < 0) k1 = k;
        else begin k2 = k; rd = obs_rdata; break; end
      end
    end
    req_read = 1'b0;
    @(posedge clk); #1;
    check_lat("b2b_first_lat", k1, LAT_A);
    check_lat("b2b_gap", k2 - k1, LAT_A + 1);
    check_val("b2b_data", rd, 32'hDEADBEEF);

    // read and write together: write wins, read data untouched
    txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 0, lat, rd);
    txn(1'b1, 1'b1, 32'h0000_0030, 32'h0BADC0DE, 4'b1111, 0, lat, rd);
    check_lat("both_lat", lat, LAT_A);
    check_val("both_rdata_held", rd, 32'h11AB3344);
    txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'b0000, 0, lat, rd);
    check_val("both_wrote", rd, 32'h0BADC0DE);

    // request dropped after one edge still completes
    txn(1'b0, 1'b1, 32'h0000_0044, 32'h13579BDF, 4'b1111, 1, lat, rd);
    check_lat("drop_lat", lat, LAT_A);
    txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b0000, 0, lat, rd);
    check_val("drop_data", rd, 32'h13579BDF);

    // reset mid-WAIT on the LATENCY=4 instance
    rst_a = 1'b0; sel = 1; rst_b = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 1'b1, 32'h0000_0040, 32'hCAFEF00D, 4'b1111, 0, lat, rd);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 0, lat, rd);
    check_lat("b_rd_lat", lat, LAT_B);
    check_val("b_rd_data", rd, 32'hCAFEF00D);
    req_write = 1'b1; req_addr = 32'h0000_0040; req_wdata = 32'h12345678; req_be = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("pre_rst_busy", 32'(obs_busy), 32'd1);
    rst_b = 1'b0;
    #1;
    check_val("abort_resp", 32'(obs_resp), 32'd0);
    check_val("abort_busy", 32'(obs_busy), 32'd0);
    check_val("abort_rdata", obs_rdata, 32'd0);
    req_write = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (obs_resp) pulses++;
    end
    check_val("no_resp_after_rst", 32'(pulses), 32'd0);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'b0000, 0, lat, rd);
    check_val("abort_word_kept", rd, 32'hCAFEF00D);

`ifdef MEM_RESPONDER_STALL_EN
    // random stall latencies on the LATENCY=1 instance
    rst_b = 1'b0; sel = 2; rst_c = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      txn(1'b0, 1'b1, 32'(i * 4), 32'hA0000000 | (32'(i) * 32'h01010101), 4'b1111, 0, lat, rd);
    for (int n = 0; n < 200; n++) begin
      int a;
      a = int'($urandom_range(0, 7));
      txn(1'b1, 1'b0, 32'(a * 4), 32'h0, 4'b0000, 0, lat, rd);
      check_lat("stall_lat", lat, LAT_C);
      check_val("stall_data", rd, 32'hA0000000 | (32'(a) * 32'h01010101));
      if (lat >= 1 && lat <= 4) hist[lat]++;
    end
    for (int i = 1; i <= 4; i++) check_val("stall_hist_seen", 32'(hist[i] > 0), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
